// File: rtl/gate_op_arb_pkg.sv
// -----------------------------------------------------------------------------
// gate_op_arb_pkg
// Shared definitions for the gate-op arbiter: opcode encodings and the
// bitwise gate evaluation function. The datapath and its bench model both
// call gate_eval so there is a single definition of each operation.
// gate_eval works on a fixed maximum width. Callers zero-extend their
// operands to that width and keep the low W bits of the result.
// -----------------------------------------------------------------------------
package gate_op_arb_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_AND  = 3'd0;
    localparam opcode_t OP_OR   = 3'd1;
    localparam opcode_t OP_NOT  = 3'd2;
    localparam opcode_t OP_NAND = 3'd3;
    localparam opcode_t OP_NOR  = 3'd4;
    localparam opcode_t OP_XOR  = 3'd5;
    localparam opcode_t OP_XNOR = 3'd6;
    localparam opcode_t OP_RSVD = 3'd7;

    localparam int GATE_MAX_W = 64;
    typedef logic [GATE_MAX_W-1:0] gate_word_t;

    // The reserved opcode returns zero. It still completes, so a requester
    // that issues it always receives a result.
    function automatic gate_word_t gate_eval(opcode_t op, gate_word_t a, gate_word_t b);
        gate_word_t r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = ~a;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_op_arb_if.sv
// -----------------------------------------------------------------------------
// gate_op_arb_if
// Bundles the requester-side bus of the gate-op arbiter.
//   req/op/a/b : per-requester request, opcode and operands (driven by clients)
//   gnt        : one-hot grant pulse back to the clients
//   res_valid/res_id/res : tagged result
//   busy       : activity indicator
// Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface gate_op_arb_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) ();
    logic [N-1:0]   req;
    logic [3*N-1:0] op;
    logic [W*N-1:0] a;
    logic [W*N-1:0] b;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic [IDW-1:0] res_id;
    logic [W-1:0]   res;
    logic           busy;

    modport master (
        output req, op, a, b,
        input  gnt, res_valid, res_id, res, busy
    );

    modport slave (
        input  req, op, a, b,
        output gnt, res_valid, res_id, res, busy
    );
endinterface

// File: rtl/gate_op_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Finds the first eligible index at or
// above ptr_i, wrapping modulo N.
//   elig_i  : eligible request vector
//   ptr_i   : round-robin start index (always < N)
//   gnt_o   : one-hot pick (all zero when nothing is eligible)
//   idx_o   : encoded pick
//   valid_o : a pick was made
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   elig_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           valid_o
);

    always_comb begin
        int c;
        // NOTE: every output gets a default before the search loop, so no
        // path leaves a value unassigned and no latch is inferred.
        c       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            c = (int'(ptr_i) + off) % N;
            if (!valid_o && elig_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// -----------------------------------------------------------------------------
// gate_op_arbiter
// Shares one registered bitwise logic unit among N requesters. A round-robin
// arbiter grants at most one request per cycle. The grant edge captures that
// requester's opcode and operands into a stage register. The next edge writes
// the tagged result.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gate_op_arb_if.slave (req/op/a/b in; gnt/res_valid/res_id/res/busy out)
// Optional (macro GATE_OP_ARB_STATS_EN):
//   cnt_clr   : synchronous clear of the grant counter (wins over increment)
//   grant_cnt : 16-bit saturating count of grants
// -----------------------------------------------------------------------------
module gate_op_arbiter
    import gate_op_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic                clk,
    input  logic                rst,
    gate_op_arb_if.slave        bus
`ifdef GATE_OP_ARB_STATS_EN
    ,
    input  logic                cnt_clr,
    output logic [15:0]         grant_cnt
`endif
);

    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           stg_valid_q, stg_valid_d;
    logic [IDW-1:0] stg_id_q, stg_id_d;
    opcode_t        stg_op_q, stg_op_d;
    logic [W-1:0]   stg_a_q, stg_a_d;
    logic [W-1:0]   stg_b_q, stg_b_d;
    logic           res_valid_q, res_valid_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [W-1:0]   res_q, res_d;

    logic [N-1:0]   elig;
    logic [N-1:0]   arb_gnt;
    logic [IDW-1:0] arb_idx;
    logic           arb_valid;
    gate_word_t     eval;

    // A requester holding gnt this cycle is masked, so it is never picked
    // twice in a row while it drops its request.
    assign elig = bus.req & ~gnt_q;

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr_arbiter (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        gnt_d       = arb_gnt;
        stg_valid_d = arb_valid;
        ptr_d       = ptr_q;
        stg_id_d    = stg_id_q;
        stg_op_d    = stg_op_q;
        stg_a_d     = stg_a_q;
        stg_b_d     = stg_b_q;
        if (arb_valid) begin
            ptr_d    = (arb_idx == IDW'(N - 1)) ? '0 : arb_idx + IDW'(1);
            stg_id_d = arb_idx;
            stg_op_d = bus.op[3*int'(arb_idx) +: 3];
            stg_a_d  = bus.a[W*int'(arb_idx) +: W];
            stg_b_d  = bus.b[W*int'(arb_idx) +: W];
        end

        // The result registers hold their last value while no result is due.
        eval        = gate_eval(stg_op_q, GATE_MAX_W'(stg_a_q), GATE_MAX_W'(stg_b_q));
        res_valid_d = stg_valid_q;
        res_id_d    = res_id_q;
        res_d       = res_q;
        if (stg_valid_q) begin
            res_id_d = stg_id_q;
            res_d    = eval[W-1:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            ptr_q       <= '0;
            stg_valid_q <= 1'b0;
            stg_id_q    <= '0;
            stg_op_q    <= OP_AND;
            stg_a_q     <= '0;
            stg_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            stg_valid_q <= stg_valid_d;
            stg_id_q    <= stg_id_d;
            stg_op_q    <= stg_op_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_q       <= res_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res       = res_q;
    assign bus.busy      = (|bus.req) | res_valid_q;

`ifdef GATE_OP_ARB_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (cnt_clr) begin
            grant_cnt_d = '0;
        end else if (arb_valid && grant_cnt_q != 16'hFFFF) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among N requesters.
- A round-robin arbiter grants at most one request per cycle and captures that requester's operands.
- The logic unit returns a tagged result one cycle after the grant.
- Sits between multiple control FSMs and the team's basic-gate datapath, so one gate array serves many clients.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- IDW, 2, requester-ID width; must equal clog2(N) and be at least 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request; must be held until the matching gnt bit is seen.
- op  input  3*N  per-requester opcode, packed; requester i uses op[3i+2:3i].
- a  input  W*N  per-requester operand A, packed.
- b  input  W*N  per-requester operand B, packed; ignored for NOT.
- gnt  output  N  registered one-hot grant pulse, one cycle wide.
- res_valid  output  1  result valid pulse.
- res_id  output  IDW  index of the requester that owns the result.
- res  output  W  result data.
- busy  output  1  high when any req bit is high or res_valid is high.

Behaviour:
- Reset, asynchronous and immediate: gnt=0, res_valid=0, res_id=0, res=0, round-robin pointer=0.
- Opcodes: 0 AND, 1 OR, 2 NOT (~a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved → res=0.
- Opcode 7 still produces res_valid so the requester is not stranded.
- Eligible set = req & ~gnt. A requester granted this cycle is not eligible again; the requester drops req on seeing gnt.
- Arbitration, cycle T:
  - If the eligible set is non-empty, choose the first eligible index at or above ptr, wrapping modulo N.
  - At the edge ending T: gnt[k] set for one cycle; op/a/b of k captured into the stage register; ptr ← (k+1) mod N.
- Execution, cycle T+1: gnt[k]=1.
  - At the edge ending T+1: res ← f(op,a,b), res_id ← k, res_valid ← 1 for one cycle.
  - Result visible in T+2; latency is 2 edges from the cycle req is sampled.
- Throughput: one grant per cycle with back-to-back grants to different requesters. Stage and result registers form a 2-deep pipeline with no stall; results are always accepted.
- Empty eligible set: gnt=0, ptr unchanged, no res_valid two edges later.
- Single requester holding req continuously: granted every other cycle (gnt cycle masks it).
- Requester dropping req before grant: request is withdrawn; nothing issued.
- rst mid-operation: pipelined results are discarded, no res_valid follows, ptr returns to 0.
- res holds its last value when res_valid=0.

Optional Feature:
- Macro: GATE_OP_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, width 16: saturating count of total grants, reset 0, stops at 0xFFFF.
  - Adds input cnt_clr, width 1: synchronous clear, with priority over an increment in the same cycle.
- When undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package gate_op_arb_pkg:
  - Opcode localparams OP_AND..OP_XNOR and OP_RSVD.
  - A function gate_eval(op,a,b) returning W bits, shared with the datapath bench model.
- Sub-module rr_arbiter (N): eligible vector and ptr in, one-hot grant and encoded index out. Purely combinational; ptr register stays in the top.

Test Plan:
- Reset then idle, N=4, W=8: after rst deasserts, gnt, res_valid, res_id and res stay 0 for 10 cycles; busy=0.
- Single op: req[2]=1, op=5 (XOR), a=8'hF0, b=8'h3C.
  - Expect gnt=4'b0100 at T+1.
  - Expect res_valid=1, res_id=2, res=8'hCC at T+2.
- Fairness: all four req held permanently.
  - Expect grant order 0,1,2,3,0,…
  - Same requester never in consecutive cycles.
  - After 8 grants each requester granted exactly 2 times.
- Wrap: ptr=3 with req=4'b1001.
  - Expect gnt[3] first.
  - req[0] granted the following cycle; ptr ends at 1.
- All opcodes on requester 1, a=8'hA5, b=8'h0F:
  - AND 05, OR AF, NOT 5A, NAND FA, NOR 50, XOR AA, XNOR 55, op 7 → 00.
  - Each result carries res_id=1.
- Reset mid-flight: assert rst in the cycle gnt[0]=1. Expect no res_valid afterwards; next grant after release goes to the lowest requesting index.
